// File: rtl/image_stream_loader.sv
// Packs a byte-serial pixel stream into the classifier's image bus, waits a settle
// window, then returns the captured one-hot classification on a valid/ready port.
module image_stream_loader #(
   parameter int unsigned NPIX       = 784,
   parameter int unsigned PIXW       = 8,
   parameter int unsigned NCLS       = 10,
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [PIXW-1:0]      s_data,
   input  logic                 s_last,
   output logic [NPIX*PIXW-1:0] img_data,
   input  logic [NCLS-1:0]      model_out,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [3:0]           m_class,
   output logic [NCLS-1:0]      m_onehot,
   output logic                 m_err,
   output logic                 busy
);

   localparam int unsigned CW  = $clog2(NPIX);
   localparam int unsigned SW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int unsigned PCW = $clog2(NCLS + 1);
   localparam int unsigned IW  = NPIX * PIXW;

   typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_RESULT} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    set_q, set_d;
   logic [IW-1:0]    buf_q, buf_d;
   logic             err_q, err_d;
   logic             s_ready_q, s_ready_d;
   logic             m_valid_q, m_valid_d;
   logic [3:0]       m_class_q, m_class_d;
   logic [NCLS-1:0]  m_onehot_q, m_onehot_d;
   logic             m_err_q, m_err_d;
   logic             busy_q, busy_d;
   logic [PCW-1:0]   pop_c;
   logic [3:0]       cls_c;
   logic             beat_c;

   assign beat_c = s_valid & s_ready_q;

   // Popcount and lowest-set-bit encode of the classifier output
   always_comb begin
      pop_c = '0;
      cls_c = '0;
      for (int i = NCLS - 1; i >= 0; i--) begin
         pop_c = pop_c + PCW'(model_out[i]);
         if (model_out[i]) cls_c = 4'(i);
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      set_d      = set_q;
      buf_d      = buf_q;
      err_d      = err_q;
      m_valid_d  = m_valid_q;
      m_class_d  = m_class_q;
      m_onehot_d = m_onehot_q;
      m_err_d    = m_err_q;
      case (state_q)
         ST_LOAD: begin
            if (beat_c) begin
               buf_d[cnt_q*PIXW +: PIXW] = s_data;
               if (cnt_q == CW'(NPIX - 1)) begin
                  cnt_d   = '0;
                  set_d   = '0;
                  state_d = ST_SETTLE;
                  if (!s_last) err_d = 1'b1;
               end else if (s_last) begin
                  // short frame: drop it, keep loading from pixel 0
                  cnt_d = '0;
                  err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_SETTLE: begin
            if (set_q == SW'(SETTLE_CYC - 1)) begin
               m_onehot_d = model_out;
               m_class_d  = cls_c;
               m_err_d    = (pop_c != PCW'(1)) | err_q;
               m_valid_d  = 1'b1;
               state_d    = ST_RESULT;
            end else begin
               set_d = set_q + SW'(1);
            end
         end
         ST_RESULT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               err_d     = 1'b0;
               state_d   = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
      s_ready_d = (state_d == ST_LOAD);
      busy_d    = (state_d != ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_LOAD;
         cnt_q      <= '0;
         set_q      <= '0;
         buf_q      <= '0;
         err_q      <= 1'b0;
         s_ready_q  <= 1'b0;
         m_valid_q  <= 1'b0;
         m_class_q  <= '0;
         m_onehot_q <= '0;
         m_err_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         set_q      <= set_d;
         buf_q      <= buf_d;
         err_q      <= err_d;
         s_ready_q  <= s_ready_d;
         m_valid_q  <= m_valid_d;
         m_class_q  <= m_class_d;
         m_onehot_q <= m_onehot_d;
         m_err_q    <= m_err_d;
         busy_q     <= busy_d;
      end
   end

   assign s_ready  = s_ready_q;
   assign img_data = buf_q;
   assign m_valid  = m_valid_q;
   assign m_class  = m_class_q;
   assign m_onehot = m_onehot_q;
   assign m_err    = m_err_q;
   assign busy     = busy_q;

endmodule
